procb_buf: RTL and testbench

Per-thread buffer of process_bytes (procb) records between the record writer (program/CPU side) and `process_bytes`. Each thread owns a small circular queue. The consumer reads show-ahead through a lookup pointer and then commits with a read pointer, so records fetched for a block that did not go can be rewound. It feeds `procb_dout` / `procb_lookup_empty` of `process_bytes` and obeys its `procb_lookup_en`, `procb_rd_en` and `procb_rd_rst`.

---
 rtl/procb_buf.sv | 136 +++++++++++++
 tb/tb_procb_buf.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/procb_buf.sv
// Per-thread circular queues of procb records with show-ahead lookup and rewindable commit.
// Optional sticky protocol-error flag enabled by defining PROCB_BUF_CHECK_EN.
module procb_buf #(
    parameter int N_CORES       = 3,
    parameter int N_THREADS     = 4 * N_CORES,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
    parameter int DEPTH_MSB     = 1,
    parameter int PROCB_D_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_THREADS_MSB:0]   wr_thread_num,
    input  logic                     wr_en,
    input  logic [PROCB_D_WIDTH-1:0] din,
    input  logic                     wr_clr,
    output logic                     full,
    input  logic [N_THREADS_MSB:0]   rd_thread_num,
    input  logic                     lookup_en,
    input  logic                     rd_en,
    input  logic                     rd_rst,
    output logic                     lookup_empty,
    output logic [PROCB_D_WIDTH-1:0] dout,
    output logic                     err
);

    localparam int PW    = DEPTH_MSB + 2;
    localparam int DEPTH = 2 ** (DEPTH_MSB + 1);
    localparam int AW    = N_THREADS_MSB + DEPTH_MSB + 2;

    typedef logic [PW-1:0] ptr_t;

    ptr_t wp_q [N_THREADS];
    ptr_t wp_d [N_THREADS];
    ptr_t lp_q [N_THREADS];
    ptr_t lp_d [N_THREADS];
    ptr_t rp_q [N_THREADS];
    ptr_t rp_d [N_THREADS];

    logic [PROCB_D_WIDTH-1:0] mem [N_THREADS*DEPTH];

    logic          rd_block;
    logic          do_wr;
    logic          do_lk;
    logic          do_cm;
    logic          cm_legal;
    ptr_t          rp_new;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign full = ptr_t'(wp_q[wr_thread_num] - rp_q[wr_thread_num])
                  == ptr_t'(DEPTH);
    assign lookup_empty = lp_q[rd_thread_num] == wp_q[rd_thread_num];

    // Clearing a thread freezes any consumer activity on that same thread.
    assign rd_block = wr_clr && (wr_thread_num == rd_thread_num);
    assign cm_legal = rp_q[rd_thread_num] != lp_q[rd_thread_num];
    assign do_wr    = wr_en && !full && !wr_clr;
    assign do_lk    = lookup_en && !lookup_empty && !rd_rst && !rd_block;
    assign do_cm    = rd_en && cm_legal && !rd_block;
    assign rp_new   = rp_q[rd_thread_num] + ptr_t'(do_cm);

    assign wr_addr = {wr_thread_num, wp_q[wr_thread_num][DEPTH_MSB:0]};
    assign rd_addr = {rd_thread_num, lp_q[rd_thread_num][DEPTH_MSB:0]};

    assign dout = lookup_empty ? '0 : mem[rd_addr];

    always_comb begin
        wp_d = wp_q;
        lp_d = lp_q;
        rp_d = rp_q;
        rp_d[rd_thread_num] = rp_new;
        if (rd_rst && !rd_block) begin
            lp_d[rd_thread_num] = rp_new;
        end else if (do_lk) begin
            lp_d[rd_thread_num] = lp_q[rd_thread_num] + ptr_t'(1);
        end
        if (wr_clr) begin
            wp_d[wr_thread_num] = rp_q[wr_thread_num];
            lp_d[wr_thread_num] = rp_q[wr_thread_num];
            rp_d[wr_thread_num] = rp_q[wr_thread_num];
        end else if (do_wr) begin
            wp_d[wr_thread_num] = wp_q[wr_thread_num] + ptr_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_THREADS; i++) begin
                wp_q[i] <= '0;
                lp_q[i] <= '0;
                rp_q[i] <= '0;
            end
        end else begin
            wp_q <= wp_d;
            lp_q <= lp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_addr] <= din;
        end
    end

`ifdef PROCB_BUF_CHECK_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q;
        if (wr_en && full && !wr_clr) begin
            err_d = 1'b1;
        end
        if (lookup_en && lookup_empty && !rd_rst && !rd_block) begin
            err_d = 1'b1;
        end
        if (rd_en && !cm_legal && !rd_block) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_procb_buf.sv
// Directed vector table plus hand-written sequences for procb_buf.
module tb_procb_buf;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   wt;
    logic [3:0]   rt;
    logic         wen;
    logic         clr;
    logic         lk;
    logic         rd;
    logic         rrst;
    logic [W-1:0] din;
    logic         full;
    logic         empty;
    logic [W-1:0] dout;
    logic         err;
    logic         exp_err = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    procb_buf dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .wr_thread_num(wt),
        .wr_en        (wen),
        .din          (din),
        .wr_clr       (clr),
        .full         (full),
        .rd_thread_num(rt),
        .lookup_en    (lk),
        .rd_en        (rd),
        .rd_rst       (rrst),
        .lookup_empty (empty),
        .dout         (dout),
        .err          (err)
    );

    typedef struct {
        logic [3:0]   wt;
        logic         wen;
        logic [W-1:0] din;
        logic         clr;
        logic [3:0]   rt;
        logic         lk;
        logic         rd;
        logic         rrst;
        logic         efull;
        logic         eempty;
        logic [W-1:0] edout;
    } vec_t;

    vec_t vq[$];

    logic [W-1:0] q3[$];
    logic [W-1:0] q5[$];
    int           ml3 = 0;

    task automatic chk(input string nm, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic void add(input logic [3:0] a_wt, input logic a_wen,
                                input logic [W-1:0] a_din, input logic a_clr,
                                input logic [3:0] a_rt, input logic a_lk,
                                input logic a_rd, input logic a_rrst,
                                input logic a_full, input logic a_empty,
                                input logic [W-1:0] a_dout);
        vec_t v;
        v.wt = a_wt; v.wen = a_wen; v.din = a_din; v.clr = a_clr;
        v.rt = a_rt; v.lk = a_lk; v.rd = a_rd; v.rrst = a_rrst;
        v.efull = a_full; v.eempty = a_empty; v.edout = a_dout;
        vq.push_back(v);
    endfunction

    task automatic idle();
        wen = 0; clr = 0; lk = 0; rd = 0; rrst = 0; din = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Look up every remaining record (checking order) then commit them all.
    task automatic drain(input logic [3:0] t, input logic [W-1:0] exp[$],
                         input int lpos);
        idle();
        wt = t;
        rt = t;
        for (int k = lpos; k < exp.size(); k++) begin
            lk = 1;
            #2;
            chk($sformatf("drain t%0d dout %0d", t, k), dout, exp[k]);
            tick();
        end
        lk = 0;
        #2;
        chk($sformatf("drain t%0d empty", t), W'(empty), W'(1));
        for (int k = 0; k < exp.size(); k++) begin
            rd = 1;
            tick();
        end
        rd = 0;
        #2;
        chk($sformatf("drain t%0d full", t), W'(full), W'(0));
    endtask

    initial begin
        wt = 0; rt = 0;
        idle();

        // thread 2: A, B written, looked up in order
        add(2, 1, 16'hA001, 0, 2, 0, 0, 0, 0, 1, 16'h0000);
        add(2, 1, 16'hB002, 0, 2, 0, 0, 0, 0, 0, 16'hA001);
        add(2, 0, 16'h0000, 0, 2, 1, 0, 0, 0, 0, 16'hA001);
        add(2, 0, 16'h0000, 0, 2, 1, 0, 0, 0, 0, 16'hB002);
        add(2, 0, 16'h0000, 0, 2, 0, 0, 0, 0, 1, 16'h0000);
        add(2, 0, 16'h0000, 0, 2, 0, 1, 0, 0, 1, 16'h0000);
        add(2, 0, 16'h0000, 0, 2, 0, 1, 0, 0, 1, 16'h0000);
        // thread 1: rewind after partial commit, rewind with commit
        add(1, 1, 16'h1111, 0, 1, 0, 0, 0, 0, 1, 16'h0000);
        add(1, 1, 16'h2222, 0, 1, 0, 0, 0, 0, 0, 16'h1111);
        add(1, 1, 16'h3333, 0, 1, 0, 0, 0, 0, 0, 16'h1111);
        add(1, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 16'h1111);
        add(1, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 16'h2222);
        add(1, 0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 16'h3333);
        add(1, 0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, 16'h3333);
        add(1, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 16'h2222);
        add(1, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 16'h2222);
        add(1, 0, 16'h0000, 0, 1, 0, 1, 1, 0, 0, 16'h3333);
        add(1, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 16'h3333);
        add(1, 0, 16'h0000, 0, 1, 1, 0, 1, 0, 0, 16'h3333);
        add(1, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 16'h3333);
        // thread 4: clear with simultaneous write and lookup
        add(4, 1, 16'h4001, 0, 4, 0, 0, 0, 0, 1, 16'h0000);
        add(4, 1, 16'h4002, 0, 4, 0, 0, 0, 0, 0, 16'h4001);
        add(4, 1, 16'h4003, 0, 4, 0, 0, 0, 0, 0, 16'h4001);
        add(4, 1, 16'h4444, 1, 4, 1, 0, 0, 0, 0, 16'h4001);
        add(4, 0, 16'h0000, 0, 4, 0, 0, 0, 0, 1, 16'h0000);
        add(4, 1, 16'h4005, 0, 4, 0, 0, 0, 0, 1, 16'h0000);
        add(4, 0, 16'h0000, 0, 4, 0, 0, 0, 0, 0, 16'h4005);

        #1;
        chk("reset empty", W'(empty), W'(1));
        chk("reset full", W'(full), W'(0));
        chk("reset dout", dout, '0);
        chk("reset err", W'(err), W'(0));
        @(negedge clk);
        rst_n = 1;
        tick();

        foreach (vq[i]) begin
            wt = vq[i].wt; wen = vq[i].wen; din = vq[i].din;
            clr = vq[i].clr; rt = vq[i].rt; lk = vq[i].lk;
            rd = vq[i].rd; rrst = vq[i].rrst;
            #2;
            chk($sformatf("vec%0d full", i), W'(full), W'(vq[i].efull));
            chk($sformatf("vec%0d empty", i), W'(empty), W'(vq[i].eempty));
            chk($sformatf("vec%0d dout", i), dout, vq[i].edout);
            tick();
        end

        // thread 0: fill, dropped write, free a slot, wrap
        idle();
        wt = 0;
        rt = 0;
        for (int i = 0; i < 4; i++) begin
            wen = 1;
            din = W'(16'h0D00 + i);
            #2;
            chk($sformatf("t0 fill full %0d", i), W'(full), W'(0));
            tick();
        end
        wen = 1;
        din = 16'hDEAD;
        #2;
        chk("t0 full at 4", W'(full), W'(1));
        tick();
        wen = 0;
`ifdef PROCB_BUF_CHECK_EN
        exp_err = 1'b1;
`endif
        #2;
        chk("t0 err after drop", W'(err), W'(exp_err));
        chk("t0 still full", W'(full), W'(1));
        lk = 1;
        #2;
        chk("t0 first dout", dout, 16'h0D00);
        tick();
        lk = 0;
        rd = 1;
        #2;
        chk("t0 full during commit", W'(full), W'(1));
        tick();
        rd = 0;
        #2;
        chk("t0 full after commit", W'(full), W'(0));
        wen = 1;
        din = 16'h0D04;
        tick();
        wen = 0;
        #2;
        chk("t0 full after wrap write", W'(full), W'(1));
        for (int i = 1; i <= 4; i++) begin
            lk = 1;
            #2;
            chk($sformatf("t0 wrap dout %0d", i), dout, W'(16'h0D00 + i));
            tick();
        end
        lk = 0;
        #2;
        chk("t0 wrap empty", W'(empty), W'(1));
        chk("t0 wrap dout0", dout, '0);
        for (int i = 0; i < 4; i++) begin
            rd = 1;
            tick();
        end
        rd = 0;

        // threads 5 and 3: writer alternates, reader works thread 3
        begin
            int written;
            written = 0;
            for (int c = 0; c < 400 && written < 100; c++) begin
                logic [3:0] w;
                logic       efull;
                logic       do_w;
                logic       do_r;
                logic       do_l;
                logic [W-1:0] val;
                idle();
                w = (c % 2 == 1) ? 4'd3 : 4'd5;
                wt = w;
                rt = 3;
                efull = (w == 3) ? (q3.size() == 4) : (q5.size() == 4);
                do_w = !efull && ($urandom_range(0, 3) != 0);
                do_r = (ml3 > 0) && ($urandom_range(0, 1) == 1);
                do_l = (ml3 < q3.size()) && ($urandom_range(0, 3) != 0);
                val = W'($urandom);
                wen = do_w;
                din = val;
                rd = do_r;
                lk = do_l;
                #2;
                chk($sformatf("mix%0d full", c), W'(full), W'(efull));
                chk($sformatf("mix%0d empty", c), W'(empty),
                    W'(ml3 == q3.size()));
                if (do_l) begin
                    chk($sformatf("mix%0d dout", c), dout, q3[ml3]);
                end
                tick();
                if (do_r) begin
                    void'(q3.pop_front());
                    ml3--;
                end
                if (do_l) begin
                    ml3++;
                end
                if (do_w) begin
                    written++;
                    if (w == 3) q3.push_back(val);
                    else q5.push_back(val);
                end
            end
            chk("mix written", W'(written), W'(100));
        end
        drain(5, q5, 0);
        drain(3, q3, ml3);

        // thread 6: asynchronous reset with records queued
        idle();
        wt = 6;
        rt = 6;
        wen = 1;
        din = 16'h6001;
        tick();
        din = 16'h6002;
        tick();
        wen = 0;
        #2;
        chk("t6 dout before reset", dout, 16'h6001);
        rst_n = 0;
        #1;
        chk("async rst empty", W'(empty), W'(1));
        chk("async rst full", W'(full), W'(0));
        chk("async rst dout", dout, '0);
        chk("async rst err", W'(err), W'(0));
        @(negedge clk);
        rst_n = 1;
        tick();
        #2;
        chk("post rst empty", W'(empty), W'(1));
        wt = 0;
        #1;
        chk("post rst t0 full", W'(full), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
